// File: rtl/pe_clk_gate_ctrl_pkg.sv
// rtl/pe_clk_gate_ctrl_pkg.sv - shared types and default constants for the PE clock-gating controller
package pe_clk_pkg;

    // Per-domain gating state
    typedef enum logic [1:0] {
        OFF  = 2'b00,
        WAKE = 2'b01,
        ON   = 2'b10
    } dom_state_t;

    localparam int DEF_N_DOM       = 4;
    localparam int DEF_IDLE_CYCLES = 16;
    localparam int DEF_WAKE_CYCLES = 2;
    localparam int DEF_IDLE_W      = 8;

endpackage

// File: rtl/pe_clk_gate_ctrl_if.sv
// rtl/pe_clk_gate_ctrl_if.sv - handshake bundle between array controller and clock-gating controller
//   force_on, sleep_req, dom_req[N_DOM], dom_busy[N_DOM] : controller -> gating block
//   sleep_ack, clk_en[N_DOM], dom_rdy[N_DOM]              : gating block -> controller / gating cells
interface pe_clk_gate_ctrl_if #(
    parameter int N_DOM = 4
);
    logic             force_on;
    logic             sleep_req;
    logic             sleep_ack;
    logic [N_DOM-1:0] dom_req;
    logic [N_DOM-1:0] dom_busy;
    logic [N_DOM-1:0] clk_en;
    logic [N_DOM-1:0] dom_rdy;

    modport master (
        output force_on, sleep_req, dom_req, dom_busy,
        input  sleep_ack, clk_en, dom_rdy
    );

    modport slave (
        input  force_on, sleep_req, dom_req, dom_busy,
        output sleep_ack, clk_en, dom_rdy
    );
endinterface

// File: rtl/pe_clk_gate_ctrl_dom_fsm.sv
// rtl/pe_clk_gate_ctrl_dom_fsm.sv - one gated domain: OFF/WAKE/ON state machine with wake and idle counters
//   clk, rst                               : free-running clock, async active-high reset
//   force_on, sleep_req, dom_req, dom_busy : control inputs for this domain
//   state                                  : current state (for sleep reduction and statistics)
//   clk_en, dom_rdy                        : registered enable and ready
module pe_clk_dom_fsm
    import pe_clk_pkg::*;
#(
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int IDLE_W      = DEF_IDLE_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       force_on,
    input  logic       sleep_req,
    input  logic       dom_req,
    input  logic       dom_busy,
    output dom_state_t state,
    output logic       clk_en,
    output logic       dom_rdy
);
    localparam int                WAKE_W    = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    dom_state_t        state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [WAKE_W-1:0] wake_q, wake_d;
    logic              en_q, rdy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OFF;
            idle_q  <= '0;
            wake_q  <= '0;
            en_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
            // Dedicated flops rather than a decode of state_q, so the enable into
            // the gating cell never glitches on a WAKE->ON code change.
            en_q    <= (state_d != OFF);
            rdy_q   <= (state_d == ON);
        end
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        case (state_q)
            OFF: begin
                idle_d = '0;
                wake_d = '0;
                if ((dom_req || force_on) && !(sleep_req && !force_on))
                    state_d = WAKE;
            end
            WAKE: begin
                // Wake always runs to completion regardless of req/sleep changes.
                if (wake_q == WAKE_LAST) begin
                    state_d = ON;
                    idle_d  = '0;
                end else begin
                    wake_d = wake_q + 1'b1;
                end
            end
            ON: begin
                if (sleep_req && !force_on && !dom_busy) begin
                    state_d = OFF;
                end else if (dom_req || dom_busy || force_on) begin
                    // Activity wins over a coincident timeout.
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = OFF;
                end else if (idle_q != '1) begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = OFF;
        endcase
    end

    assign state   = state_q;
    assign clk_en  = en_q;
    assign dom_rdy = rdy_q;

endmodule

// File: rtl/pe_clk_gate_ctrl.sv
// rtl/pe_clk_gate_ctrl.sv - activity-driven clock-gating controller for the PE gated domains
//   clk, rst : free-running PE clock, async active-high reset
//   bus      : pe_clk_gate_ctrl_if.slave (force_on, sleep_req/ack, dom_req, dom_busy, clk_en, dom_rdy)
//   CLK_GATE_STATS_EN defined: stat_sel (in) selects a domain, stat_gated (out, 32) gives its
//   saturating count of clock edges spent OFF.
module pe_clk_gate_ctrl
    import pe_clk_pkg::*;
#(
    parameter int N_DOM       = DEF_N_DOM,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int IDLE_W      = DEF_IDLE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    pe_clk_gate_ctrl_if.slave        bus
`ifdef CLK_GATE_STATS_EN
    ,
    input  logic [$clog2(N_DOM)-1:0] stat_sel,
    output logic [31:0]              stat_gated
`endif
);
    logic [N_DOM-1:0] dom_off;
    logic [N_DOM-1:0] clk_en_w;
    logic [N_DOM-1:0] dom_rdy_w;
    logic             sleep_ack_q;

    for (genvar i = 0; i < N_DOM; i++) begin : g_dom
        dom_state_t st;

        pe_clk_dom_fsm #(
            .IDLE_CYCLES(IDLE_CYCLES),
            .WAKE_CYCLES(WAKE_CYCLES),
            .IDLE_W     (IDLE_W)
        ) u_dom (
            .clk      (clk),
            .rst      (rst),
            .force_on (bus.force_on),
            .sleep_req(bus.sleep_req),
            .dom_req  (bus.dom_req[i]),
            .dom_busy (bus.dom_busy[i]),
            .state    (st),
            .clk_en   (clk_en_w[i]),
            .dom_rdy  (dom_rdy_w[i])
        );

        assign dom_off[i] = (st == OFF);
    end

    // force_on keeps ack low even on the edge where OFF domains are just leaving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sleep_ack_q <= 1'b0;
        else     sleep_ack_q <= bus.sleep_req && !bus.force_on && (&dom_off);
    end

    assign bus.sleep_ack = sleep_ack_q;
    assign bus.clk_en    = clk_en_w;
    assign bus.dom_rdy   = dom_rdy_w;

`ifdef CLK_GATE_STATS_EN
    logic [31:0] gated_cnt [N_DOM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_DOM; i++) gated_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_DOM; i++)
                if (dom_off[i] && (gated_cnt[i] != '1))
                    gated_cnt[i] <= gated_cnt[i] + 32'd1;
        end
    end

    assign stat_gated = gated_cnt[stat_sel];
`endif

endmodule
